pc_ctrl: RTL and testbench

Program-flow controller that sequences the `pc` instruction-address counter. Each cycle it takes branch, call, return and halt requests from the instruction decoder and drives the counter's `jmp`, `jmp_addr`, `ret` and `ret_addr` inputs. It keeps a hardware return-address stack (LIFO) for nested calls. On stack overflow or underflow it enters a sticky fault state, and it freezes the program counter while halted or faulted.

---
 rtl/pc_ctrl_pkg.sv | 10 +
 rtl/ret_stack.sv | 49 ++++
 rtl/pc_ctrl.sv | 109 ++++++++++
 tb/tb_pc_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types for the program-flow controller.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } pc_ctrl_state_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO: synchronous push/pop, top is always visible combinationally.
module ret_stack #(
  parameter int W     = 6,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [0:(1<<AW)-1];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_idx, top_idx;

  assign wr_idx  = cnt_q[AW-1:0];
  // Wraps to a stale slot when empty; callers ignore top in that case.
  assign top_idx = wr_idx - AW'(1);

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign top   = mem_q[top_idx];

  always_comb begin
    cnt_d = cnt_q;
    if (push && !full)      cnt_d = cnt_q + CW'(1);
    else if (pop && !empty) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Contents are deliberately not reset; only the count is.
  always_ff @(posedge clk) begin
    if (!rst && push && !full) mem_q[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-flow controller: resolves halt/call/ret/branch into pc jmp/ret controls
// and tracks nested calls in a return-address stack.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int INSTR_ADDR_SIZE = 6,
  parameter int STACK_DEPTH     = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [INSTR_ADDR_SIZE-1:0]         instr_addr,
  input  logic                               br_req,
  input  logic                               br_cond,
  input  logic [INSTR_ADDR_SIZE-1:0]         br_target,
  input  logic                               call_req,
  input  logic [INSTR_ADDR_SIZE-1:0]         call_target,
  input  logic                               ret_req,
  input  logic                               halt_req,
  input  logic                               resume,
  output logic                               jmp,
  output logic [INSTR_ADDR_SIZE-1:0]         jmp_addr,
  output logic                               ret,
  output logic [INSTR_ADDR_SIZE-1:0]         ret_addr,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_cnt,
  output logic                               halted,
  output logic                               fault
);

  localparam int W = INSTR_ADDR_SIZE;

  pc_ctrl_state_t state_q, state_d;
  logic [W-1:0]   addr_inc;
  logic           push, pop, stk_full, stk_empty;

  assign addr_inc = instr_addr + W'(1);

  ret_stack #(.W(W), .DEPTH(STACK_DEPTH)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (addr_inc),
    .top   (ret_addr),
    .count (stack_cnt),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (halt_req)                   state_d = HALT;
        else if (call_req && stk_full)  state_d = FAULT;
        else if (!call_req && ret_req && stk_empty) state_d = FAULT;
      end
      HALT:    if (resume) state_d = RUN;
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
  end

  // Outputs: hold (jmp to self) is the safe default outside RUN.
  always_comb begin
    jmp      = 1'b0;
    jmp_addr = instr_addr;
    ret      = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (halt_req) begin
            jmp      = 1'b1;
            jmp_addr = addr_inc;
          end else if (call_req) begin
            jmp = 1'b1;
            if (stk_full) begin
              jmp_addr = instr_addr;
            end else begin
              jmp_addr = call_target;
              push     = 1'b1;
            end
          end else if (ret_req) begin
            if (stk_empty) begin
              jmp = 1'b1;
            end else begin
              ret = 1'b1;
              pop = 1'b1;
            end
          end else if (br_req && br_cond) begin
            jmp      = 1'b1;
            jmp_addr = br_target;
          end
        end
        default: jmp = 1'b1;
      endcase
    end
  end

  assign halted = (state_q == HALT);
  assign fault  = (state_q == FAULT);

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: call/return, overflow, underflow, branch, halt, wrap, priority.
module tb_pc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] instr_addr, br_target, call_target;
  logic       br_req, br_cond, call_req, ret_req, halt_req, resume;
  logic       jmp, ret, halted, fault;
  logic [5:0] jmp_addr, ret_addr;
  logic [2:0] stack_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_ctrl #(.INSTR_ADDR_SIZE(6), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .instr_addr(instr_addr),
    .br_req(br_req), .br_cond(br_cond), .br_target(br_target),
    .call_req(call_req), .call_target(call_target), .ret_req(ret_req),
    .halt_req(halt_req), .resume(resume),
    .jmp(jmp), .jmp_addr(jmp_addr), .ret(ret), .ret_addr(ret_addr),
    .stack_cnt(stack_cnt), .halted(halted), .fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    br_req = 0; br_cond = 0; call_req = 0; ret_req = 0; halt_req = 0; resume = 0;
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; instr_addr = 5; br_target = 0; call_target = 0;
    idle();
    halt_req = 1;
    #1;
    chk("rst_jmp", jmp, 0);
    chk("rst_ret", ret, 0);
    tick();
    chk("rst_cnt", stack_cnt, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    rst = 0; idle();

    // call at 5 -> 20, return at 22
    instr_addr = 5; call_req = 1; call_target = 20; #1;
    chk("call_jmp", jmp, 1);
    chk("call_addr", jmp_addr, 20);
    chk("call_ret0", ret, 0);
    tick(); idle(); instr_addr = 20; #1;
    chk("call_cnt", stack_cnt, 1);
    chk("call_top", ret_addr, 6);
    chk("noreq_jmp", jmp, 0);
    chk("noreq_addr", jmp_addr, 20);
    tick(); instr_addr = 22; ret_req = 1; #1;
    chk("ret_ret", ret, 1);
    chk("ret_jmp", jmp, 0);
    chk("ret_addr", ret_addr, 6);
    tick(); idle(); #1;
    chk("ret_cnt", stack_cnt, 0);

    // branch not taken / taken
    instr_addr = 10; br_req = 1; br_cond = 0; br_target = 3; #1;
    chk("brnt_jmp", jmp, 0);
    chk("brnt_addr", jmp_addr, 10);
    tick(); instr_addr = 11; br_cond = 1; #1;
    chk("brt_jmp", jmp, 1);
    chk("brt_addr", jmp_addr, 3);
    tick(); idle();

    // call beats branch
    instr_addr = 30; call_req = 1; call_target = 50; br_req = 1; br_cond = 1; br_target = 7; #1;
    chk("pri_addr", jmp_addr, 50);
    tick(); idle(); #1;
    chk("pri_cnt", stack_cnt, 1);
    chk("pri_top", ret_addr, 31);
    instr_addr = 50; ret_req = 1; br_req = 1; br_cond = 1; #1;
    chk("pri_ret", ret, 1);
    chk("pri_ret_jmp", jmp, 0);
    tick(); idle(); #1;
    chk("pri_cnt0", stack_cnt, 0);

    // wrap: call at 63 pushes 0
    instr_addr = 63; call_req = 1; call_target = 0; #1;
    chk("wrap_addr", jmp_addr, 0);
    tick(); idle(); #1;
    chk("wrap_top", ret_addr, 0);
    chk("wrap_cnt", stack_cnt, 1);
    ret_req = 1; #1;
    chk("wrap_ret", ret, 1);
    tick(); idle(); #1;
    chk("wrap_cnt0", stack_cnt, 0);

    // halt at 12 (halt beats call), hold 10 cycles, resume
    instr_addr = 12; halt_req = 1; call_req = 1; call_target = 40; #1;
    chk("halt_jmp", jmp, 1);
    chk("halt_addr", jmp_addr, 13);
    tick(); halt_req = 0; instr_addr = 13; #1;
    chk("halt_halted", halted, 1);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("hold_jmp", jmp, 1);
      chk("hold_addr", jmp_addr, 13);
      chk("hold_ret", ret, 0);
      tick();
    end
    chk("hold_cnt", stack_cnt, 0);
    idle(); resume = 1; #1;
    chk("resume_jmp", jmp, 1);
    chk("resume_addr", jmp_addr, 13);
    tick(); idle(); #1;
    chk("resume_halted", halted, 0);
    chk("resume_step", jmp, 0);

    // underflow at 9
    instr_addr = 9; ret_req = 1; #1;
    chk("uf_ret", ret, 0);
    chk("uf_jmp", jmp, 1);
    chk("uf_addr", jmp_addr, 9);
    tick(); idle(); #1;
    chk("uf_fault", fault, 1);
    rst = 1; tick(); rst = 0; #1;
    chk("uf_clr", fault, 0);

    // overflow: 4 nested calls, 5th at 40
    for (int i = 0; i < 4; i++) begin
      instr_addr = 6'(i + 1); call_req = 1; call_target = 6'(i + 10);
      tick();
    end
    idle(); #1;
    chk("of_cnt4", stack_cnt, 4);
    chk("of_top", ret_addr, 5);
    instr_addr = 40; call_req = 1; call_target = 20; #1;
    chk("of_jmp", jmp, 1);
    chk("of_addr", jmp_addr, 40);
    tick(); #1;
    chk("of_fault", fault, 1);
    chk("of_cnt", stack_cnt, 4);
    for (int i = 0; i < 20; i++) begin
      call_req = i[0]; ret_req = i[1]; halt_req = i[2]; resume = i[3];
      br_req = 1; br_cond = 1; br_target = 2;
      #1;
      chk("fhold_jmp", jmp, 1);
      chk("fhold_addr", jmp_addr, 40);
      chk("fhold_ret", ret, 0);
      tick();
    end
    idle(); #1;
    chk("fhold_fault", fault, 1);
    chk("fhold_cnt", stack_cnt, 4);
    chk("fhold_halted", halted, 0);
    rst = 1; tick(); rst = 0; #1;
    chk("of_rst_fault", fault, 0);
    chk("of_rst_cnt", stack_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
